// File: rtl/wb_half_bridge.sv
// Wishbone 32-bit slave window bridged onto a 16-bit internal bus.
// Each Wishbone access is split into at most two halfword transactions.
module wb_half_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFF00_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ib_req_o,
  output logic        ib_we_o,
  output logic [22:0] ib_adr_o,
  output logic [1:0]  ib_sel_o,
  output logic [15:0] ib_dat_o,
  input  logic [15:0] ib_dat_i,
  input  logic        ib_ack_i,
  input  logic        ib_err_i,
  output logic        err_o
);

  // state | meaning
  // IDLE  | waiting for a hit on the decoded window
  // LO    | low halfword transaction (adr bit0 = 0)
  // HI    | high halfword transaction (adr bit0 = 1)
  // DONE  | one-cycle Wishbone ack (suppressed if cyc dropped)
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [7:0] WAIT_LOAD = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [21:0] adr_q, adr_nxt;
  logic [15:0] hi_dat_q, hi_dat_nxt;
  logic [1:0]  hi_sel_q, hi_sel_nxt;
  logic        we_q, we_nxt;
  logic        abort_q, abort_nxt;
  logic [7:0]  wait_left, wait_left_nxt;
  logic [31:0] rd_buf, rd_buf_nxt;
  logic        ack_nxt, req_nxt, ib_we_nxt, err_nxt;
  logic [22:0] ib_adr_nxt;
  logic [1:0]  ib_sel_nxt;
  logic [15:0] ib_dat_nxt;

  logic hit, expired, abort_now, fail;
  logic [15:0] half_data;

  assign hit       = wbs_cyc_i & wbs_stb_i &
                     ((wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
  assign expired   = ib_req_o & ~ib_ack_i & ~ib_err_i & (wait_left == 8'd0);
  assign abort_now = abort_q | ~wbs_cyc_i;
  // Error wins over a simultaneous ack; timeouts complete the same way.
  assign fail      = ib_req_o & (ib_err_i | expired);
  assign half_data = fail ? 16'hFFFF : ib_dat_i;

  assign wbs_dat_o = rd_buf;

  always_comb begin
    state_nxt     = state;
    adr_nxt       = adr_q;
    hi_dat_nxt    = hi_dat_q;
    hi_sel_nxt    = hi_sel_q;
    we_nxt        = we_q;
    abort_nxt     = abort_q;
    wait_left_nxt = wait_left;
    rd_buf_nxt    = rd_buf;
    ack_nxt       = 1'b0;
    req_nxt       = ib_req_o;
    ib_we_nxt     = ib_we_o;
    ib_adr_nxt    = ib_adr_o;
    ib_sel_nxt    = ib_sel_o;
    ib_dat_nxt    = ib_dat_o;
    err_nxt       = err_o;

    unique case (state)
      IDLE: begin
        abort_nxt = 1'b0;
        if (hit) begin
          adr_nxt       = wbs_adr_i[23:2];
          hi_dat_nxt    = wbs_dat_i[31:16];
          hi_sel_nxt    = wbs_sel_i[3:2];
          we_nxt        = wbs_we_i;
          rd_buf_nxt    = 32'h0;
          wait_left_nxt = WAIT_LOAD;
          ib_we_nxt     = wbs_we_i;
          if (wbs_sel_i[1:0] != 2'b00) begin
            state_nxt  = LO;
            ib_adr_nxt = {wbs_adr_i[23:2], 1'b0};
            ib_sel_nxt = wbs_sel_i[1:0];
            ib_dat_nxt = wbs_dat_i[15:0];
          end else if (wbs_sel_i[3:2] != 2'b00) begin
            state_nxt  = HI;
            ib_adr_nxt = {wbs_adr_i[23:2], 1'b1};
            ib_sel_nxt = wbs_sel_i[3:2];
            ib_dat_nxt = wbs_dat_i[31:16];
          end else begin
            state_nxt = DONE;
            ack_nxt   = 1'b1;
          end
        end
      end

      LO, HI: begin
        if (!wbs_cyc_i) abort_nxt = 1'b1;
        if (!ib_req_o) begin
          req_nxt = 1'b1;
        end else if (fail || ib_ack_i) begin
          req_nxt = 1'b0;
          if (fail) err_nxt = 1'b1;
          if (fail || !we_q) begin
            if (state == HI) rd_buf_nxt[31:16] = half_data;
            else             rd_buf_nxt[15:0]  = half_data;
          end
          if (!fail && state == LO && hi_sel_q != 2'b00 && !abort_now) begin
            state_nxt     = HI;
            wait_left_nxt = WAIT_LOAD;
            ib_adr_nxt    = {adr_q, 1'b1};
            ib_sel_nxt    = hi_sel_q;
            ib_dat_nxt    = hi_dat_q;
          end else begin
            state_nxt = DONE;
            ack_nxt   = ~abort_now;
          end
        end else begin
          wait_left_nxt = wait_left - 8'd1;
        end
      end

      DONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      adr_q     <= '0;
      hi_dat_q  <= '0;
      hi_sel_q  <= '0;
      we_q      <= 1'b0;
      abort_q   <= 1'b0;
      wait_left <= '0;
      rd_buf    <= '0;
      wbs_ack_o <= 1'b0;
      ib_req_o  <= 1'b0;
      ib_we_o   <= 1'b0;
      ib_adr_o  <= '0;
      ib_sel_o  <= '0;
      ib_dat_o  <= '0;
      err_o     <= 1'b0;
    end else begin
      state     <= state_nxt;
      adr_q     <= adr_nxt;
      hi_dat_q  <= hi_dat_nxt;
      hi_sel_q  <= hi_sel_nxt;
      we_q      <= we_nxt;
      abort_q   <= abort_nxt;
      wait_left <= wait_left_nxt;
      rd_buf    <= rd_buf_nxt;
      wbs_ack_o <= ack_nxt;
      ib_req_o  <= req_nxt;
      ib_we_o   <= ib_we_nxt;
      ib_adr_o  <= ib_adr_nxt;
      ib_sel_o  <= ib_sel_nxt;
      ib_dat_o  <= ib_dat_nxt;
      err_o     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_wb_half_bridge.sv
// Directed bench for wb_half_bridge with a combinational zero-wait slave
// whose ack/err can be enabled per step; TIMEOUT is 4 for the timeout case.
module tb_wb_half_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        wb_ack;
  logic [31:0] wb_rdat;
  logic        ib_req, ib_we;
  logic [22:0] ib_adr;
  logic [1:0]  ib_sel;
  logic [15:0] ib_wdat;
  logic [15:0] ib_rdat;
  logic        ib_ack, ib_err;
  logic        err;
  logic        ack_en, err_en, stray_ack, stray_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign ib_ack = (ib_req & ack_en) | stray_ack;
  assign ib_err = (ib_req & err_en) | stray_err;

  wb_half_bridge #(.TIMEOUT(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(wb_ack),
    .wbs_dat_o(wb_rdat),
    .ib_req_o (ib_req),
    .ib_we_o  (ib_we),
    .ib_adr_o (ib_adr),
    .ib_sel_o (ib_sel),
    .ib_dat_o (ib_wdat),
    .ib_dat_i (ib_rdat),
    .ib_ack_i (ib_ack),
    .ib_err_i (ib_err),
    .err_o    (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
  endtask

  task automatic stop_bus();
    cyc = 1'b0; stb = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    ib_rdat = 16'h0; ack_en = 0; err_en = 0; stray_ack = 0; stray_err = 0;
    tick(); tick();
    chk("rst_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_dat", wb_rdat, 32'd0);
    chk("rst_req", {31'd0, ib_req}, 32'd0);
    chk("rst_ibadr", {9'd0, ib_adr}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 32-bit write, zero-wait slave
    ack_en = 1;
    start(1'b1, 4'hF, 32'h3000_0008, 32'hCAFE_1234);
    tick();  // edge0: hit
    chk("w_c1_req", {31'd0, ib_req}, 32'd0);
    chk("w_c1_adr", {9'd0, ib_adr}, 32'h4);
    chk("w_c1_we", {31'd0, ib_we}, 32'd1);
    tick();
    chk("w_c2_req", {31'd0, ib_req}, 32'd1);
    chk("w_c2_dat", {16'd0, ib_wdat}, 32'h1234);
    chk("w_c2_sel", {30'd0, ib_sel}, 32'h3);
    chk("w_c2_ack", {31'd0, wb_ack}, 32'd0);
    tick();
    chk("w_c3_req", {31'd0, ib_req}, 32'd0);
    chk("w_c3_adr", {9'd0, ib_adr}, 32'h5);
    tick();
    chk("w_c4_req", {31'd0, ib_req}, 32'd1);
    chk("w_c4_dat", {16'd0, ib_wdat}, 32'hCAFE);
    chk("w_c4_ack", {31'd0, wb_ack}, 32'd0);
    tick();
    chk("w_c5_ack", {31'd0, wb_ack}, 32'd1);
    chk("w_c5_req", {31'd0, ib_req}, 32'd0);
    tick();  // stb still high through DONE: must not re-sample
    chk("w_c6_ack", {31'd0, wb_ack}, 32'd0);
    chk("w_c6_adr", {9'd0, ib_adr}, 32'h5);
    stop_bus();
    tick();
    chk("w_c7_req", {31'd0, ib_req}, 32'd0);

    // 16-bit read of upper half
    ib_rdat = 16'hBEEF;
    start(1'b0, 4'b1100, 32'h3000_0010, 32'h0);
    tick();
    chk("r_c1_adr", {9'd0, ib_adr}, 32'h9);
    chk("r_c1_req", {31'd0, ib_req}, 32'd0);
    tick();
    chk("r_c2_req", {31'd0, ib_req}, 32'd1);
    chk("r_c2_we", {31'd0, ib_we}, 32'd0);
    tick();
    chk("r_c3_ack", {31'd0, wb_ack}, 32'd1);
    chk("r_c3_dat", wb_rdat, 32'hBEEF_0000);
    stop_bus();
    tick();
    chk("r_c4_ack", {31'd0, wb_ack}, 32'd0);

    // sel == 0: immediate ack, cleared read data
    start(1'b0, 4'h0, 32'h3000_0040, 32'h0);
    tick();
    chk("s0_ack", {31'd0, wb_ack}, 32'd1);
    chk("s0_dat", wb_rdat, 32'd0);
    chk("s0_req", {31'd0, ib_req}, 32'd0);
    stop_bus();
    tick();
    chk("s0_ack_end", {31'd0, wb_ack}, 32'd0);

    // miss
    start(1'b1, 4'hF, 32'h2000_0000, 32'h1111_2222);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("miss_ack", {31'd0, wb_ack}, 32'd0);
      chk("miss_req", {31'd0, ib_req}, 32'd0);
    end
    stop_bus();
    tick();

    // timeout on LO with silent slave (TIMEOUT=4)
    ack_en = 0;
    start(1'b0, 4'hF, 32'h3000_0000, 32'h0);
    tick();  // edge0
    chk("to_c1_req", {31'd0, ib_req}, 32'd0);
    tick(); tick(); tick(); tick();
    chk("to_c5_req", {31'd0, ib_req}, 32'd1);
    chk("to_c5_err", {31'd0, err}, 32'd0);
    chk("to_c5_ack", {31'd0, wb_ack}, 32'd0);
    tick();
    chk("to_c6_ack", {31'd0, wb_ack}, 32'd1);
    chk("to_c6_req", {31'd0, ib_req}, 32'd0);
    chk("to_c6_dat", wb_rdat, 32'h0000_FFFF);
    chk("to_c6_err", {31'd0, err}, 32'd1);
    stop_bus();
    tick(); tick();
    chk("to_sticky", {31'd0, err}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("err_clr", {31'd0, err}, 32'd0);

    // ib_err on LO skips HI
    err_en = 1;
    start(1'b0, 4'hF, 32'h3000_0020, 32'h0);
    tick();
    tick();
    chk("e_c2_req", {31'd0, ib_req}, 32'd1);
    tick();
    chk("e_c3_ack", {31'd0, wb_ack}, 32'd1);
    chk("e_c3_dat", wb_rdat, 32'h0000_FFFF);
    chk("e_c3_err", {31'd0, err}, 32'd1);
    chk("e_c3_adr", {9'd0, ib_adr}, 32'h10);
    err_en = 0;
    stop_bus();
    tick();
    chk("e_c4_req", {31'd0, ib_req}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // reset while in HI
    ack_en = 1;
    start(1'b1, 4'hF, 32'h3000_0008, 32'h5555_AAAA);
    tick(); tick();
    chk("rh_c2_req", {31'd0, ib_req}, 32'd1);
    tick();
    ack_en = 0;
    chk("rh_c3_adr", {9'd0, ib_adr}, 32'h5);
    tick();
    chk("rh_c4_req", {31'd0, ib_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rh_c5_req", {31'd0, ib_req}, 32'd0);
    chk("rh_c5_ack", {31'd0, wb_ack}, 32'd0);
    chk("rh_c5_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    stop_bus();
    tick();
    chk("rh_c6_ack", {31'd0, wb_ack}, 32'd0);
    chk("rh_c6_req", {31'd0, ib_req}, 32'd0);

    // cyc drops mid-LO: in-flight half finishes, HI skipped, no ack
    start(1'b1, 4'hF, 32'h3000_0008, 32'h5555_AAAA);
    tick(); tick();
    chk("cd_c2_req", {31'd0, ib_req}, 32'd1);
    stop_bus();
    tick();
    chk("cd_c3_req", {31'd0, ib_req}, 32'd1);
    ack_en = 1;
    tick();
    chk("cd_c4_req", {31'd0, ib_req}, 32'd0);
    chk("cd_c4_ack", {31'd0, wb_ack}, 32'd0);
    chk("cd_c4_adr", {9'd0, ib_adr}, 32'h4);
    tick();
    chk("cd_c5_ack", {31'd0, wb_ack}, 32'd0);
    chk("cd_c5_req", {31'd0, ib_req}, 32'd0);

    // stray ack/err while req low is ignored
    ack_en = 0;
    ib_rdat = 16'h5A5A;
    start(1'b0, 4'b0011, 32'h3000_0100, 32'h0);
    tick();
    stray_ack = 1; stray_err = 1;
    tick();
    stray_ack = 0; stray_err = 0;
    chk("st_c2_req", {31'd0, ib_req}, 32'd1);
    chk("st_c2_err", {31'd0, err}, 32'd0);
    ack_en = 1;
    tick();
    chk("st_c3_ack", {31'd0, wb_ack}, 32'd1);
    chk("st_c3_dat", wb_rdat, 32'h0000_5A5A);
    chk("st_c3_err", {31'd0, err}, 32'd0);
    stop_bus();
    ack_en = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
